// File: rtl/my_112l_pkg.sv
// Shared types for the hazard/pipeline-control unit.
//   sb_entry_t  : scoreboard slot {valid, rd, regwrite, load}
//   ex_entry_t  : EX slot = sb_entry_t plus source registers and use bits
//   fwd_sel_e   : EX operand select encoding
// Register fields are RD_MAX_W bits wide. Narrower RF addresses are
// zero-extended into them. RF_ADDRESS must not exceed RD_MAX_W.
package my_112l_pkg;

    localparam int RD_MAX_W = 8;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                regwrite;
        logic                load;
    } sb_entry_t;

    typedef struct packed {
        sb_entry_t           e;
        logic [RD_MAX_W-1:0] rs1;
        logic [RD_MAX_W-1:0] rs2;
        logic                use1;
        logic                use2;
    } ex_entry_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // True when slot s will write a non-zero register equal to r.
    function automatic logic slot_writes(sb_entry_t s, logic [RD_MAX_W-1:0] r);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   reset : synchronous active-low clear
//   inc   : count enable; ignored once the counter reaches all-ones
//   cnt   : current count
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core.
// Tracks in-flight destinations in EX/MEM/WB scoreboard slots and drives
// PC/IF-ID enables, ID/EX bubble, flushes, stage enable and EX forwarding
// selects. Priority: mem_busy > redirect > stall > normal.
// Build option: HAZARD_FWD_EN
//   defined   : EX forwarding, 1-cycle load-use stall
//   undefined : no forwarding (fwd_* = 00), RAW stall against EX, MEM and
//               (when RF_WRITE_THROUGH = 0) WB slots
// Ports:
//   clk, reset (sync, active-low)
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
//   id_load      : instruction currently in ID
//   redirect     : taken control transfer resolved in MEM
//   mem_busy     : data memory stall, freezes the pipeline
//   pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem,
//   stage_en     : pipeline control
//   fwd_a, fwd_b : EX operand selects (00 RF, 01 MEM/WB, 10 EX/MEM)
//   stall_cnt, flush_cnt : saturating performance counters
module hazard_ctrl
    import my_112l_pkg::*;
#(
    parameter int RF_ADDRESS       = 5,
    parameter int CNT_W            = 32,
    parameter int RF_WRITE_THROUGH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_load,
    input  logic                  redirect,
    input  logic                  mem_busy,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  flush_exmem,
    output logic                  stage_en,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    ex_entry_t ex_q;
    sb_entry_t mem_q;
    sb_entry_t wb_q;

    logic [RD_MAX_W-1:0] rs1_x, rs2_x, rd_x;
    logic                stall;
    fwd_sel_e            sel_a, sel_b;
    logic                unused_bits;

    assign rs1_x = RD_MAX_W'(id_rs1);
    assign rs2_x = RD_MAX_W'(id_rs2);
    assign rd_x  = RD_MAX_W'(id_rd);

    function automatic logic id_hit(sb_entry_t s, logic [RD_MAX_W-1:0] r1,
                                    logic [RD_MAX_W-1:0] r2, logic u1, logic u2);
        return (u1 && slot_writes(s, r1)) || (u2 && slot_writes(s, r2));
    endfunction

    function automatic fwd_sel_e pick_fwd(logic [RD_MAX_W-1:0] r, logic u);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (ex_q.e.valid && u) begin
            if (slot_writes(mem_q, r))     sel = FWD_MEM;
            else if (slot_writes(wb_q, r)) sel = FWD_WB;
        end
        return sel;
    endfunction

    // Hazard detection and forwarding.
    always_comb begin
        stall = 1'b0;
        sel_a = FWD_RF;
        sel_b = FWD_RF;
`ifdef HAZARD_FWD_EN
        stall = ex_q.e.load
              && id_hit(ex_q.e, rs1_x, rs2_x, id_use_rs1, id_use_rs2);
        if (reset) begin
            sel_a = pick_fwd(ex_q.rs1, ex_q.use1);
            sel_b = pick_fwd(ex_q.rs2, ex_q.use2);
        end
`else
        stall = id_hit(ex_q.e, rs1_x, rs2_x, id_use_rs1, id_use_rs2)
             || id_hit(mem_q,  rs1_x, rs2_x, id_use_rs1, id_use_rs2)
             || ((RF_WRITE_THROUGH == 0)
                 && id_hit(wb_q, rs1_x, rs2_x, id_use_rs1, id_use_rs2));
`endif
    end

`ifdef HAZARD_FWD_EN
    assign unused_bits = ^{mem_q.load, wb_q.load, (RF_WRITE_THROUGH != 0)};
`else
    assign unused_bits = ^{ex_q.e.load, mem_q.load, wb_q.load,
                           ex_q.rs1, ex_q.rs2, ex_q.use1, ex_q.use2,
                           (RF_WRITE_THROUGH != 0)};
    // pick_fwd only exists for the forwarding build's selects
    logic unused_fwd;
    assign unused_fwd = ^pick_fwd(ex_q.rs1, 1'b0);
`endif

    // Control outputs.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        stage_en    = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (reset) begin
            if (mem_busy) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                stage_en   = 1'b0;
            end else if (redirect) begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
            end else if (stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

    // Scoreboard shift. Redirect drops the old EX contents on their way
    // into MEM; redirect and stall both leave an empty EX slot behind.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_busy) begin
            wb_q        <= mem_q;
            mem_q       <= ex_q.e;
            if (redirect) mem_q.valid <= 1'b0;
            if (redirect || stall) begin
                ex_q <= '0;
            end else begin
                ex_q.e.valid    <= id_valid;
                ex_q.e.rd       <= rd_x;
                ex_q.e.regwrite <= id_regwrite;
                ex_q.e.load     <= id_load;
                ex_q.rs1        <= rs1_x;
                ex_q.rs2        <= rs2_x;
                ex_q.use1       <= id_use_rs1;
                ex_q.use2       <= id_use_rs2;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!mem_busy && !redirect && stall),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!mem_busy && redirect),
        .cnt   (flush_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the 5-stage RISC-V core (IF/ID/EX/MEM/WB).
- Replaces the fixed PC_Write / IFID_Write / ControlMux hook points in the core.
- Keeps an internal scoreboard of in-flight destinations (EX, MEM, WB slots) and drives stall, bubble, flush and forwarding selects.
- Counts stall cycles and flush events in saturating performance counters.

Parameters:
RF_ADDRESS, 5, register-file address width
CNT_W, 32, width of the performance counters
RF_WRITE_THROUGH, 1, 1 = the register file bypasses a same-cycle WB write to ID reads, so the WB slot never causes a hazard

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  RF_ADDRESS  ID source 1
id_rs2  in  RF_ADDRESS  ID source 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_rd  in  RF_ADDRESS  ID destination
id_regwrite  in  1  ID writes rd
id_load  in  1  ID is a load
redirect  in  1  taken branch/jal/jalr resolved in MEM
mem_busy  in  1  data memory not ready; freeze the pipeline
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
idex_bubble  out  1  zero the control fields entering ID/EX
flush_ifid  out  1  clear IF/ID
flush_idex  out  1  clear ID/EX
flush_exmem  out  1  clear EX/MEM
stage_en  out  1  enable for ID/EX, EX/MEM and MEM/WB
fwd_a  out  2  EX operand A select: 00 = RF, 01 = MEM/WB, 10 = EX/MEM
fwd_b  out  2  EX operand B select, same encoding as fwd_a
stall_cnt  out  CNT_W  count of load-use/RAW stall cycles
flush_cnt  out  CNT_W  count of redirects accepted

Behaviour:
- Scoreboard slots EX, MEM and WB each hold {valid, rd, regwrite, load}. The EX slot also holds rs1/rs2 and their use bits.
- Reset (reset=0 at a clk edge) clears:
  - all slots and both counters;
  - all flush outputs, idex_bubble and fwd_a/fwd_b.
- During reset, pc_write, ifid_write and stage_en are 1.
- Outputs are combinational from the slots plus the current ID, redirect and mem_busy inputs. The slots update on clk.
- Priority: mem_busy > redirect > stall > normal.
- mem_busy=1:
  - pc_write, ifid_write and stage_en are 0; no flush; slots and counters hold.
  - redirect is ignored; its source holds it until mem_busy drops.
- redirect=1 (mem_busy=0):
  - flush_ifid, flush_idex and flush_exmem are 1; pc_write=1.
  - Next cycle: EX slot invalid; MEM slot takes the (invalidated) old EX contents; WB slot takes the old MEM contents, which is the branch itself.
  - flush_cnt is incremented.
- Load-use stall: the EX slot is valid, load, regwrite, with rd!=0, and rd equals an ID source that is used.
  - pc_write=0, ifid_write=0, idex_bubble=1.
  - Next cycle: EX slot invalid; MEM and WB slots shift as normal.
  - stall_cnt is incremented. The stall lasts exactly 1 cycle.
- Normal advance: EX slot loads the ID fields (valid = id_valid); MEM takes EX; WB takes MEM.
- Forwarding (EX-slot rs vs older slots):
  - select 10 if MEM is valid, regwrite, rd!=0 and matches;
  - otherwise select 01 if WB is valid, regwrite, rd!=0 and matches;
  - otherwise 00.
  - MEM has priority. x0 is never forwarded. Selects are 00 when the EX slot is invalid or the use bit is 0.
- Counters saturate at all-ones.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined: forwarding and 1-cycle load-use stalls as above.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - A RAW stall (same outputs as a load-use stall) holds while any valid regwrite slot with rd!=0 matches a used ID source. The slots checked are EX and MEM, plus WB when RF_WRITE_THROUGH=0.
  - Each stall cycle increments stall_cnt.

Decomposition:
- my_112l_pkg gets:
  - typedef sb_entry_t {valid, rd, regwrite, load};
  - enum fwd_sel_e {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
- One sub-module, sat_counter (parameter CNT_W, inputs inc and reset), instanced twice for stall_cnt and flush_cnt.

Test Plan:
- ALU RAW chain: add x5 then sub x6,x5,x1 issued back to back -> fwd_a=10 in sub's EX cycle, no stall, stall_cnt=0. A second dependent instruction 2 cycles later -> fwd_a=01.
- Load-use: lw x7 then add x8,x7,x7 -> exactly 1 cycle with pc_write=0, ifid_write=0, idex_bubble=1, then fwd_a=fwd_b=01; stall_cnt=1.
- x0 destination: lw x0 then add x1,x0,x0 -> no stall, fwd=00.
- Redirect coincident with a load-use stall -> all three flushes asserted, idex_bubble=0, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- mem_busy held 3 cycles with redirect=1 -> no flush while busy and outputs frozen; flush on the first cycle after mem_busy drops.
- Build without HAZARD_FWD_EN: add x5 then sub x6,x5,x1 -> 2 stall cycles (3 with RF_WRITE_THROUGH=0), fwd always 00. Mid-stall reset -> the next cycle shows all slots empty, pc_write=1, counters=0.
